// File: rtl/l2_req_queue_if.sv
// Handshake bundle between the L2 request merge, the OpenCAPI command/completion
// channels and the L2 control response path of l2_req_queue.
interface l2_req_queue_if #(
  parameter int nstrms_width = 6,
  parameter int tag_width    = 4
);
  // Every channel is valid/ready: a transfer happens on a rising clk edge where
  // both are high, and a raised valid holds with stable data until it transfers.
  logic                    i_req_v;
  logic                    i_req_r;
  logic [nstrms_width-1:0] i_req_sid;
  logic                    o_cmd_v;
  logic                    o_cmd_r;
  logic [nstrms_width-1:0] o_cmd_sid;
  logic [tag_width-1:0]    o_cmd_tag;
  logic                    i_cpl_v;
  logic                    i_cpl_r;
  logic [tag_width-1:0]    i_cpl_tag;
  logic                    o_rsp_v;
  logic                    o_rsp_r;
  logic [nstrms_width-1:0] o_rsp_sid;
  logic                    o_err;
  logic                    o_idle;

  modport master (
    output i_req_v, i_req_sid, o_cmd_r, i_cpl_v, i_cpl_tag, o_rsp_r,
    input  i_req_r, o_cmd_v, o_cmd_sid, o_cmd_tag, i_cpl_r, o_rsp_v, o_rsp_sid,
           o_err, o_idle
  );

  modport slave (
    input  i_req_v, i_req_sid, o_cmd_r, i_cpl_v, i_cpl_tag, o_rsp_r,
    output i_req_r, o_cmd_v, o_cmd_sid, o_cmd_tag, i_cpl_r, o_rsp_v, o_rsp_sid,
           o_err, o_idle
  );
endinterface

// File: rtl/l2_req_queue.sv
// L2 request queue: FIFO of stream requests issued as tagged OpenCAPI commands,
// completions mapped back to stream responses. Optional counters: L2_REQ_QUEUE_STATS_EN.
module l2_req_queue #(
  parameter int nstrms       = 64,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int qdepth       = 8,
  parameter int ntags        = 16,
  parameter int tag_width    = $clog2(ntags)
) (
  input  logic          clk,
  input  logic          reset,
  l2_req_queue_if.slave bus
`ifdef L2_REQ_QUEUE_STATS_EN
  ,
  output logic [31:0]   o_stat_req,
  output logic [31:0]   o_stat_cpl
`endif
);
  localparam int aw = $clog2(qdepth);

  logic [nstrms_width-1:0] fifo_mem [qdepth];
  logic [aw-1:0]           wr_ptr;
  logic [aw-1:0]           rd_ptr;
  logic [aw:0]             count;
  logic [ntags-1:0]        busy;
  logic [ntags-1:0]        busy_nxt;
  logic [nstrms_width-1:0] tag_table [ntags];
  logic                    rsp_v;
  logic [nstrms_width-1:0] rsp_sid;
  logic                    err;

  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    any_free;
  logic [tag_width-1:0]    free_tag;
  logic                    cpl_fire;
  logic                    cpl_hit;

  assign full     = (count == (aw+1)'(qdepth));
  assign empty    = (count == '0);
  assign push     = bus.i_req_v && !full;
  assign pop      = bus.o_cmd_v && bus.o_cmd_r;
  assign cpl_fire = bus.i_cpl_v && bus.i_cpl_r;
  assign cpl_hit  = cpl_fire && busy[bus.i_cpl_tag];

  // Scan downward so the last match left standing is the lowest free index.
  always_comb begin
    free_tag = '0;
    any_free = 1'b0;
    for (int i = ntags - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_tag = tag_width'(i);
        any_free = 1'b1;
      end
    end
  end

  // The issued tag is free and the completed tag is busy, so the two never collide.
  always_comb begin
    busy_nxt = busy;
    if (cpl_hit) busy_nxt[bus.i_cpl_tag] = 1'b0;
    if (pop)     busy_nxt[free_tag]      = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy   <= '0;
      rsp_v  <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      busy <= busy_nxt;
      if (cpl_hit)          rsp_v <= 1'b1;
      else if (bus.o_rsp_r) rsp_v <= 1'b0;
      if (cpl_fire && !busy[bus.i_cpl_tag]) err <= 1'b1;
    end
  end

  // Storage arrays carry no reset; validity is tracked by pointers and busy bits.
  always_ff @(posedge clk) begin
    if (push)    fifo_mem[wr_ptr]  <= bus.i_req_sid;
    if (pop)     tag_table[free_tag] <= fifo_mem[rd_ptr];
    if (cpl_hit) rsp_sid <= tag_table[bus.i_cpl_tag];
  end

`ifdef L2_REQ_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_stat_req <= '0;
      o_stat_cpl <= '0;
    end else begin
      if (pop)     o_stat_req <= o_stat_req + 32'd1;
      if (cpl_hit) o_stat_cpl <= o_stat_cpl + 32'd1;
    end
  end
`endif

  assign bus.i_req_r   = !full;
  assign bus.o_cmd_v   = !empty && any_free;
  assign bus.o_cmd_sid = fifo_mem[rd_ptr];
  assign bus.o_cmd_tag = free_tag;
  assign bus.i_cpl_r   = !rsp_v || bus.o_rsp_r;
  assign bus.o_rsp_v   = rsp_v;
  assign bus.o_rsp_sid = rsp_sid;
  assign bus.o_err     = err;
  assign bus.o_idle    = empty && (busy == '0) && !rsp_v;
endmodule
